multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

- Multi-cycle control unit for the RV32I core; the sequencing end of the ALU interface.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the ALU's `ALUOp`/`ALUSrc` plus datapath enables.
- Consumes the ALU's `zero` (branch-taken) flag and a memory ready handshake.
- Sits between the instruction register decode fields and the datapath muxes/enables.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  core clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  7  instruction[6:0], from the instruction register; valid from DECODE onward
- `zero`  in  1  ALU branch-taken flag; meaningful only while `ALUOp`=01
- `mem_ready`  in  1  memory access completes this cycle
- `ALUOp`  out  2  00 add, 01 branch compare, 10 R/I arithmetic, 11 lui
- `ALUSrc`  out  1  1 = imm32 operand, 0 = rs2
- `PCWrite`  out  1  PC register load enable
- `PCSrc`  out  1  0 = PC+4, 1 = old_pc+imm32
- `IRWrite`  out  1  instruction register load enable
- `MemRead`  out  1  memory read request
- `MemWrite`  out  1  memory write request
- `RegWrite`  out  1  register file write enable
- `WBSel`  out  2  writeback source: 00 ALUResult, 01 load data, 10 PC+4
- `illegal`  out  1  one-cycle pulse on an unsupported opcode
- `instret`  out  32  retired-instruction counter

## Operation
- State register values: FETCH, DECODE, EXEC, MEM, WB. Reset value is FETCH.
- `opcode` is sampled at the end of DECODE into `op_q`. EXEC, MEM and WB decode from `op_q` only.

FETCH:
- Outputs: `MemRead`=1, `ALUOp`=00.
- On the accept cycle: `IRWrite`=1, `PCWrite`=1, `PCSrc`=0.
- Transition: to DECODE.

DECODE:
- No enables asserted.
- Supported `opcode` values: 0110011 (R), 0010011 (I), 0000011 (load), 0100011 (store), 1100011 (branch), 0110111 (lui), 1101111 (jal).
- Supported opcode: go to EXEC.
- Any other opcode: `illegal`=1 for this cycle, then go to FETCH. `instret` is unchanged.

EXEC:
- R-type: `ALUOp`=10, `ALUSrc`=0; go to WB.
- I-type: `ALUOp`=10, `ALUSrc`=1; go to WB.
- Load/store: `ALUOp`=00, `ALUSrc`=1; go to MEM.
- lui: `ALUOp`=11, `ALUSrc`=1; go to WB.
- branch: `ALUOp`=01, `ALUSrc`=0, `PCSrc`=1, `PCWrite`=`zero`; retire; go to FETCH.
- jal: `PCSrc`=1, `PCWrite`=1, `RegWrite`=1, `WBSel`=10; retire; go to FETCH.

MEM:
- Load: `MemRead`=1; on accept go to WB.
- Store: `MemWrite`=1; on accept retire and go to FETCH.

WB:
- `RegWrite`=1.
- `WBSel`=01 for load, 00 otherwise.
- Retire; go to FETCH.

Retire and outputs:
- Retire means `instret` increments by 1 at the edge that leaves the state.
- `instret` wraps from 0xFFFFFFFF to 0.
- Every enable not listed for a state is 0. All outputs are decoded combinationally from state and `op_q`.

## Timing
- While `rst`=1: state, `op_q` and `instret` are 0 or FETCH after the edge. All outputs are forced to 0.
- The first FETCH cycle is the first cycle with `rst`=0.
- Cycles per instruction with zero memory wait:
  - branch, jal: 3
  - R, I, lui, store: 4
  - load: 5
- Accept cycle: the FETCH or MEM cycle in which the memory access completes (see Configuration).
- `IRWrite`/`PCWrite` in FETCH, and `MemWrite` completion in MEM, take effect only on the accept cycle.
- `MemRead`/`MemWrite` stay high for the whole wait.
- Reset in any state, including a wait in MEM, aborts the instruction. No retire occurs, and the next cycle is FETCH with no pending writes.
- `illegal` never coincides with `RegWrite`, `MemWrite` or `PCWrite`.

## Configuration
`MULTICYCLE_MEM_WAIT_EN`:
- Defined: the accept cycle is `mem_ready`=1. FETCH and MEM hold while `mem_ready`=0, with no wait limit.
- Undefined: `mem_ready` is ignored and treated as constant 1. FETCH and MEM always last exactly one cycle.

## Test plan
1. **Reset, then R-type.** Stimulus: `rst` high 2 cycles; opcode 0110011 (add), `mem_ready`=1. Response: cycles show FETCH(`IRWrite`,`PCWrite`), DECODE, EXEC(`ALUOp`=10, `ALUSrc`=0), WB(`RegWrite`=1). `instret` goes 0→1 after cycle 4.
2. **Load with wait** (macro defined). Stimulus: opcode 0000011; `mem_ready` low for 3 MEM cycles. Response: EXEC has `ALUOp`=00, `ALUSrc`=1; MEM lasts 4 cycles with `MemRead`=1; WB has `WBSel`=01, `RegWrite`=1. Total 8 cycles.
3. **Branch taken and not taken.** Stimulus: opcode 1100011 twice, first with `zero`=1, then with `zero`=0. Response: EXEC `ALUOp`=01 both times. `PCWrite`=1 with `PCSrc`=1 the first time; `PCWrite`=0 the second. `instret` +2, each instruction 3 cycles.
4. **Illegal opcode.** Stimulus: opcode 1111111. Response: `illegal`=1 for exactly the DECODE cycle, then FETCH. No enables asserted; `instret` unchanged.
5. **Reset mid-store.** Stimulus: opcode 0100011; `rst`=1 during MEM while `mem_ready`=0. Response: `MemWrite` drops to 0 in the reset cycle. State is FETCH on the first cycle with `rst`=0; `instret`=0.
6. **Macro undefined.** Stimulus: opcode 0000011 with `mem_ready` held 0. Response: load still completes in 5 cycles.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - RV32I multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB)
// Optional feature: define MULTICYCLE_MEM_WAIT_EN to make FETCH and MEM wait on mem_ready.
module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic [1:0]  ALUOp,
   output logic        ALUSrc,
   output logic        PCWrite,
   output logic        PCSrc,
   output logic        IRWrite,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic [1:0]  WBSel,
   output logic        illegal,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   state_t      state;
   state_t      next_state;
   logic [6:0]  op_q;
   logic [31:0] count;
   logic        retire;
   logic        accept;
   logic        op_ok;

`ifdef MULTICYCLE_MEM_WAIT_EN
   assign accept = mem_ready;
`else
   // Without the wait feature the memory is assumed single-cycle.
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign accept = 1'b1;
`endif

   assign op_ok = (opcode == OP_R)  || (opcode == OP_I)   || (opcode == OP_LD) ||
                  (opcode == OP_ST) || (opcode == OP_BR)  || (opcode == OP_LUI) ||
                  (opcode == OP_JAL);

   // The counter register reads as zero during reset, like every other output.
   assign instret = rst ? 32'd0 : count;

   // State, latched opcode and retired-instruction counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
         op_q  <= 7'd0;
         count <= 32'd0;
      end else begin
         state <= next_state;
         if (state == DECODE) op_q <= opcode;
         if (retire) count <= count + 32'd1;
      end
   end

   // Next state and per-state control outputs; reset masks every output.
   always_comb begin
      next_state = state;
      retire     = 1'b0;
      ALUOp      = 2'b00;
      ALUSrc     = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      WBSel      = 2'b00;
      illegal    = 1'b0;
      case (state)
         FETCH: begin
            MemRead = 1'b1;
            if (accept) begin
               IRWrite    = 1'b1;
               PCWrite    = 1'b1;
               next_state = DECODE;
            end
         end
         DECODE: begin
            if (op_ok) begin
               next_state = EXEC;
            end else begin
               illegal    = 1'b1;
               next_state = FETCH;
            end
         end
         EXEC: begin
            next_state = FETCH;
            case (op_q)
               OP_R: begin
                  ALUOp      = 2'b10;
                  next_state = WB;
               end
               OP_I: begin
                  ALUOp      = 2'b10;
                  ALUSrc     = 1'b1;
                  next_state = WB;
               end
               OP_LD, OP_ST: begin
                  ALUSrc     = 1'b1;
                  next_state = MEM;
               end
               OP_LUI: begin
                  ALUOp      = 2'b11;
                  ALUSrc     = 1'b1;
                  next_state = WB;
               end
               OP_BR: begin
                  ALUOp   = 2'b01;
                  PCSrc   = 1'b1;
                  PCWrite = zero;
                  retire  = 1'b1;
               end
               OP_JAL: begin
                  PCSrc    = 1'b1;
                  PCWrite  = 1'b1;
                  RegWrite = 1'b1;
                  WBSel    = 2'b10;
                  retire   = 1'b1;
               end
               default: next_state = FETCH;
            endcase
         end
         MEM: begin
            if (op_q == OP_ST) begin
               MemWrite = 1'b1;
               if (accept) begin
                  retire     = 1'b1;
                  next_state = FETCH;
               end
            end else begin
               MemRead = 1'b1;
               if (accept) next_state = WB;
            end
         end
         WB: begin
            RegWrite   = 1'b1;
            WBSel      = (op_q == OP_LD) ? 2'b01 : 2'b00;
            retire     = 1'b1;
            next_state = FETCH;
         end
         default: next_state = FETCH;
      endcase
      if (rst) begin
         ALUOp    = 2'b00;
         ALUSrc   = 1'b0;
         PCWrite  = 1'b0;
         PCSrc    = 1'b0;
         IRWrite  = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
         WBSel    = 2'b00;
         illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BAD  = 7'b1111111;

   typedef struct packed {
      logic [1:0]  alu_op;
      logic        alu_src;
      logic        pc_write;
      logic        pc_src;
      logic        ir_write;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic [1:0]  wb_sel;
      logic        illegal;
      logic [31:0] instret;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  opcode = 7'd0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b1;
   logic [1:0]  ALUOp;
   logic        ALUSrc, PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite;
   logic [1:0]  WBSel;
   logic        illegal;
   logic [31:0] instret;

   int          n_checks = 0;
   int          n_fail = 0;
   rec_t        exp_q[$];
   int          exp_instret = 0;
   int          instr_cyc = 0;
   logic        cur_zero = 1'b0;
   rec_t        cmp_e, cmp_a;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .ALUOp(ALUOp), .ALUSrc(ALUSrc), .PCWrite(PCWrite), .PCSrc(PCSrc),
      .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .WBSel(WBSel), .illegal(illegal), .instret(instret)
   );

   always #5 clk = ~clk;

   // Compare every expected cycle record against the DUT on the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cmp_e = exp_q.pop_front();
         cmp_a = '{ALUOp, ALUSrc, PCWrite, PCSrc, IRWrite, MemRead, MemWrite,
                   RegWrite, WBSel, illegal, instret};
         n_checks++;
         if (cmp_a !== cmp_e) begin
            n_fail++;
            $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, cmp_a, cmp_e);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   function automatic rec_t blank();
      rec_t e;
      e = '0;
      e.instret = exp_instret;
      return e;
   endfunction

   function automatic logic supported(input logic [6:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) ||
             (op == OP_BR) || (op == OP_LUI) || (op == OP_JAL);
   endfunction

   // mem_ready value for wait-cycle i out of w (req = requested wait count)
   function automatic logic rdy(input int i, input int w, input int req);
`ifdef MULTICYCLE_MEM_WAIT_EN
      return (i == w);
`else
      return (req == 0);
`endif
   endfunction

   task automatic step(input logic r, input logic [6:0] op, input logic mr, input rec_t e);
      @(posedge clk);
      #1;
      rst       = r;
      opcode    = op;
      mem_ready = mr;
      zero      = cur_zero;
      exp_q.push_back(e);
      instr_cyc++;
   endtask

   task automatic reset_cycles(input int n);
      rec_t e;
      e = '0;
      for (int i = 0; i < n; i++) step(1'b1, 7'd0, 1'b1, e);
      exp_instret = 0;
   endtask

   task automatic pin(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Build the expected cycle sequence of one instruction and drive its inputs.
   task automatic run_instr(input logic [6:0] op, input logic z, input int fwait,
                            input int mwait, input int abort_at);
      int   fw, mw;
      rec_t e;
      logic ld, st;
      instr_cyc = 0;
      cur_zero  = z;
      ld = (op == OP_LD);
      st = (op == OP_ST);
`ifdef MULTICYCLE_MEM_WAIT_EN
      fw = fwait;
      mw = mwait;
`else
      fw = 0;
      mw = 0;
`endif
      for (int i = 0; i <= fw; i++) begin
         e = blank();
         e.mem_read = 1'b1;
         if (i == fw) begin
            e.ir_write = 1'b1;
            e.pc_write = 1'b1;
         end
         step(1'b0, op, rdy(i, fw, fwait), e);
      end
      e = blank();
      if (!supported(op)) begin
         e.illegal = 1'b1;
         step(1'b0, op, 1'b1, e);
         return;
      end
      step(1'b0, op, 1'b1, e);
      // opcode is scrambled from here on: the DUT must use its latched copy
      e = blank();
      case (op)
         OP_R:   e.alu_op = 2'b10;
         OP_I:   begin e.alu_op = 2'b10; e.alu_src = 1'b1; end
         OP_LD,
         OP_ST:  e.alu_src = 1'b1;
         OP_LUI: begin e.alu_op = 2'b11; e.alu_src = 1'b1; end
         OP_BR:  begin e.alu_op = 2'b01; e.pc_src = 1'b1; e.pc_write = z; end
         OP_JAL: begin e.pc_src = 1'b1; e.pc_write = 1'b1; e.reg_write = 1'b1; e.wb_sel = 2'b10; end
         default: ;
      endcase
      step(1'b0, 7'd0, 1'b1, e);
      if (op == OP_BR || op == OP_JAL) begin
         exp_instret++;
         return;
      end
      if (ld || st) begin
         for (int i = 0; i <= mw; i++) begin
            if (i == abort_at) begin
               e = '0;
               step(1'b1, 7'd0, 1'b0, e);
               exp_instret = 0;
               return;
            end
            e = blank();
            if (ld) e.mem_read = 1'b1;
            else    e.mem_write = 1'b1;
            step(1'b0, 7'd0, rdy(i, mw, mwait), e);
         end
         if (st) begin
            exp_instret++;
            return;
         end
      end
      e = blank();
      e.reg_write = 1'b1;
      e.wb_sel    = ld ? 2'b01 : 2'b00;
      step(1'b0, 7'd0, 1'b1, e);
      exp_instret++;
   endtask

   initial begin
      reset_cycles(2);

      run_instr(OP_R, 1'b0, 0, 0, -1);
      pin("cpi_r", instr_cyc, 4);
      pin("instret_after_r", exp_instret, 1);

      run_instr(OP_R, 1'b0, 2, 0, -1);
`ifdef MULTICYCLE_MEM_WAIT_EN
      pin("cpi_r_fetch_wait", instr_cyc, 6);
`else
      pin("cpi_r_fetch_wait", instr_cyc, 4);
`endif

      run_instr(OP_LD, 1'b0, 0, 3, -1);
`ifdef MULTICYCLE_MEM_WAIT_EN
      pin("cpi_load_wait", instr_cyc, 8);
`else
      pin("cpi_load_wait", instr_cyc, 5);
`endif

      run_instr(OP_I, 1'b0, 0, 0, -1);
      pin("cpi_i", instr_cyc, 4);
      run_instr(OP_LUI, 1'b0, 0, 0, -1);
      pin("cpi_lui", instr_cyc, 4);
      run_instr(OP_JAL, 1'b0, 0, 0, -1);
      pin("cpi_jal", instr_cyc, 3);
      run_instr(OP_ST, 1'b0, 0, 0, -1);
      pin("cpi_store", instr_cyc, 4);

      run_instr(OP_BR, 1'b1, 0, 0, -1);
      pin("cpi_br_taken", instr_cyc, 3);
      run_instr(OP_BR, 1'b0, 0, 0, -1);
      pin("cpi_br_not_taken", instr_cyc, 3);

      run_instr(OP_BAD, 1'b0, 0, 0, -1);
      pin("cycles_illegal", instr_cyc, 2);
      pin("instret_after_illegal", exp_instret, 9);

`ifdef MULTICYCLE_MEM_WAIT_EN
      run_instr(OP_ST, 1'b0, 0, 3, 2);
      pin("cycles_store_abort", instr_cyc, 6);
`else
      run_instr(OP_ST, 1'b0, 0, 3, 0);
      pin("cycles_store_abort", instr_cyc, 4);
`endif

      run_instr(OP_R, 1'b0, 0, 0, -1);
      pin("instret_after_abort_r", exp_instret, 1);

      run_instr(OP_LD, 1'b0, 5, 5, -1);
`ifdef MULTICYCLE_MEM_WAIT_EN
      pin("cpi_load_ready_low", instr_cyc, 15);
`else
      pin("cpi_load_ready_low", instr_cyc, 5);
`endif
      pin("instret_final", exp_instret, 2);

      @(posedge clk);
      @(negedge clk);
      #1;
      pin("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
